// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, widths and the baud-divider clamp.
package uart_pkg;

   localparam int unsigned DATA_W           = 8;
   localparam logic [15:0] DEFAULT_BAUD_DIV = 16'h43D;
   localparam int unsigned MIN_DIV          = 4;

   typedef enum logic [4:0] {
      IDLE      = 5'b00001,
      START     = 5'b00010,
      DATA      = 5'b00100,
      STOP      = 5'b01000,
      WAIT_IDLE = 5'b10000
   } uart_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] min_div);
      return (div < min_div) ? min_div : div;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for an asynchronous serial line; resets to the idle (high) level.
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   assign dout = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a run-time divider latched at each start bit.
module uart_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_DIV     = uart_pkg::MIN_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_i,
   input  logic [15:0] baud_div,
   output logic [7:0]  data_out,
   output logic        rx_done,
   output logic        frame_err,
   output logic        busy
);
   import uart_pkg::*;

   logic              rx_s;
   uart_state_e       state;
   logic [15:0]       div_q;
   logic [15:0]       bit_cnt;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shift_q;
   logic              armed_q;
   logic [15:0]       half_m1;
   logic [15:0]       div_m1;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (rx_i),
      .dout (rx_s)
   );

   assign half_m1 = (div_q >> 1) - 16'd1;
   assign div_m1  = div_q - 16'd1;

   // Reset lands in WAIT_IDLE; armed_q holds it there until the synchroniser has flushed its
   // reset-high contents, so a line that is already low is never mistaken for a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= WAIT_IDLE;
         div_q     <= 16'(MIN_DIV);
         bit_cnt   <= 16'd0;
         bit_idx   <= 3'd0;
         shift_q   <= '0;
         armed_q   <= 1'b0;
         data_out  <= 8'h00;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         bit_cnt   <= bit_cnt + 16'd1;
         unique case (state)
            IDLE: begin
               bit_cnt <= 16'd0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
                  div_q <= clamp_div(baud_div, 16'(MIN_DIV));
               end
            end
            START: begin
               if (bit_cnt == half_m1) begin
                  bit_cnt <= 16'd0;
                  bit_idx <= 3'd0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (bit_cnt == div_m1) begin
                  bit_cnt <= 16'd0;
                  shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (bit_cnt == div_m1) begin
                  bit_cnt <= 16'd0;
                  if (rx_s) begin
                     data_out <= shift_q;
                     rx_done  <= 1'b1;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               if (bit_cnt == 16'(SYNC_STAGES - 1)) begin
                  armed_q <= 1'b1;
               end
               if (rx_s && armed_q) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  bit_cnt <= 16'd0;
               end
            end
            default: begin
               state   <= WAIT_IDLE;
               busy    <= 1'b0;
               bit_cnt <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a byte-level model.
module tb_uart_rx;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_i = 1'b1;
   logic [15:0] baud_div = 16'h43D;
   logic [7:0]  data_out;
   logic        rx_done;
   logic        frame_err;
   logic        busy;

   uart_rx #(
      .SYNC_STAGES (S),
      .MIN_DIV     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_i      (rx_i),
      .baud_div  (baud_div),
      .data_out  (data_out),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   int unsigned done_cyc = 0;
   int unsigned busy_cyc = 0;
   int unsigned t_fall = 0;
   logic        prev_done = 1'b0;
   logic        prev_err = 1'b0;
   logic [7:0]  last_good = 8'h00;
   logic [8:0]  obs_q[$];
   logic [8:0]  exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Strobe monitor: records every event as {is_err, data_out} and checks pulse rules.
   always @(negedge clk) begin
      if (rst && (rx_done || frame_err)) begin
         check("strobe_excl", 32'(rx_done & frame_err), 32'd0);
         check("strobe_width", 32'((rx_done & prev_done) | (frame_err & prev_err)), 32'd0);
         if (rx_done) begin
            obs_q.push_back({1'b0, data_out});
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
         end
         if (frame_err) obs_q.push_back({1'b1, data_out});
      end
      if (busy) busy_cyc++;
      prev_done = rx_done;
      prev_err  = frame_err;
   end

   task automatic hold(input logic v, input int unsigned n);
      rx_i = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int unsigned eff_div(input int unsigned d);
      return (d < 4) ? 4 : d;
   endfunction

   // Drives one 8N1 frame at the effective rate and records what the receiver should report.
   task automatic send_frame(input logic [7:0] b, input int unsigned d, input bit bad_stop,
                             input bit scramble);
      int unsigned e;
      e = eff_div(d);
      baud_div = 16'(d);
      t_fall = cyc;
      hold(1'b0, e);
      for (int i = 0; i < 8; i++) begin
         hold(b[i], e);
         if (scramble && i == 2) baud_div = 16'($urandom_range(4, 200));
      end
      if (bad_stop) begin
         hold(1'b0, 2 * e);
         hold(1'b1, e);
         exp_q.push_back({1'b1, last_good});
      end else begin
         hold(1'b1, e);
         exp_q.push_back({1'b0, b});
         last_good = b;
      end
   endtask

   task automatic settle_and_compare(input string tag);
      repeat (40) @(posedge clk);
      #1;
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0)
         check(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
      obs_q.delete();
      exp_q.delete();
   endtask

   int unsigned d;
   int unsigned lat;
   int          diff;
   logic [7:0]  b;
   bit          bad;
   bit          scr;

   initial begin
      #1;
      check("rst_data", 32'(data_out), 32'h00);
      check("rst_done", 32'(rx_done), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      hold(1'b1, 20);

      // Nominal byte at the reference rate, with latency and busy-length checks.
      busy_cyc = 0;
      send_frame(8'h4E, 32'h43D, 1'b0, 1'b0);
      settle_and_compare("nominal");
      lat  = done_cyc - t_fall;
      diff = 2 * int'(lat) - (19 * 32'h43D + 2 * S + 4);
      check("latency_window", 32'(diff >= -3 && diff <= 3), 32'd1);
      diff = 2 * int'(busy_cyc) - 19 * 32'h43D;
      check("busy_length", 32'(diff >= -4 && diff <= 4), 32'd1);

      // Back-to-back frames as a transmitter would send them.
      send_frame(8'h00, 16, 1'b0, 1'b0);
      send_frame(8'hFF, 16, 1'b0, 1'b0);
      send_frame(8'hA5, 16, 1'b0, 1'b0);
      send_frame(8'h5A, 16, 1'b0, 1'b0);
      settle_and_compare("loopback");

      // Short glitch must not produce any event.
      baud_div = 16'd16;
      hold(1'b0, 3);
      hold(1'b1, 40);
      settle_and_compare("glitch");
      check("glitch_data", 32'(data_out), 32'(last_good));
      check("glitch_busy", 32'(busy), 32'd0);

      send_frame(8'h3C, 16, 1'b1, 1'b0);
      send_frame(8'h81, 16, 1'b0, 1'b0);
      settle_and_compare("framing");

      send_frame(8'h55, 2, 1'b0, 1'b0);
      send_frame(8'hC6, 2, 1'b0, 1'b1);
      send_frame(8'h39, 20, 1'b0, 1'b1);
      settle_and_compare("clamp");

      // Reset during data bit 4 of 0xC3 (a low bit), released with the line still low.
      baud_div = 16'd16;
      hold(1'b0, 16);
      hold(1'b1, 16);
      hold(1'b1, 16);
      hold(1'b0, 16);
      hold(1'b0, 16);
      hold(1'b0, 8);
      rst = 1'b0;
      #1;
      check("midrst_data", 32'(data_out), 32'h00);
      check("midrst_done", 32'(rx_done), 32'd0);
      check("midrst_ferr", 32'(frame_err), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      last_good = 8'h00;
      hold(1'b0, 48);
      hold(1'b1, 32);
      settle_and_compare("reset_abort");
      send_frame(8'h96, 16, 1'b0, 1'b0);
      settle_and_compare("after_reset");

      for (int f = 0; f < 30; f++) begin
         d   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 24);
         b   = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         scr = 1'($urandom_range(0, 1));
         send_frame(b, d, bad, scr);
         if ($urandom_range(0, 1) == 1) hold(1'b1, $urandom_range(1, 3 * eff_div(d)));
         if (f % 5 == 4) settle_and_compare("random");
      end
      settle_and_compare("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
